// File: rtl/dct_sched_pkg.sv
// Shared constants and types for the DCT row scheduler and the DCT wrapper.
package dct_sched_pkg;

  localparam int N_ROWS   = 8;
  localparam int N_COLS   = 8;
  localparam int SAMPLE_W = 16;
  localparam int N_COMP   = 3;
  localparam int COMP_W   = $clog2(N_COMP);

  typedef logic [COMP_W-1:0] comp_t;

  typedef enum logic {
    S_IDLE,
    S_BLOCK
  } state_e;

  function automatic int comp_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dct_sched_if.sv
// Requester-side row handshake and DCT-side row/tag outputs of the scheduler.
interface dct_sched_if #(
  parameter int N_REQ = dct_sched_pkg::N_COMP,
  parameter int W_I   = dct_sched_pkg::SAMPLE_W
);
  import dct_sched_pkg::*;

  localparam int CW = comp_w(N_REQ);

  logic [N_REQ-1:0]                    req_valid;
  logic [N_REQ-1:0]                    req_ready;
  logic [N_REQ-1:0][N_COLS-1:0][W_I-1:0] req_data;
  logic [N_REQ-1:0]                    req_sof;

  logic                                dct_valid;
  logic [N_COLS-1:0][W_I-1:0]          dct_data;
  logic                                dct_sob;
  logic                                dct_eob;
  logic                                dct_sof;
  logic [CW-1:0]                       out_comp;
  logic                                out_tag_valid;
  logic                                busy;

  modport master (
    output req_valid, req_data, req_sof,
    input  req_ready, dct_valid, dct_data, dct_sob, dct_eob, dct_sof,
    input  out_comp, out_tag_valid, busy
  );

  modport slave (
    input  req_valid, req_data, req_sof,
    output req_ready, dct_valid, dct_data, dct_sob, dct_eob, dct_sof,
    output out_comp, out_tag_valid, busy
  );

endinterface

// File: rtl/dct_tag_pipe.sv
// Fixed-depth shift register carrying {valid, component} alongside the DCT pipeline.
module dct_tag_pipe #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dct_sched.sv
// Round-robin block scheduler: grants one requester the DCT for 8 consecutive rows.
module dct_sched
  import dct_sched_pkg::*;
#(
  parameter int N_REQ = N_COMP,
  parameter int PIPE  = 8,
  parameter int W_I   = SAMPLE_W
) (
  input logic        clk,
  input logic        rst,
  dct_sched_if.slave bus
);

  localparam int CW = comp_w(N_REQ);
  localparam int RW = $clog2(N_ROWS);

  typedef logic [N_COLS-1:0][W_I-1:0] row_t;

  state_e        state_q;
  logic [CW-1:0] grant_q;
  logic [CW-1:0] last_q;
  logic [RW-1:0] row_q;
  logic          dct_valid_q;
  logic          sob_q;
  logic          eob_q;
  logic          sof_q;
  row_t          dct_data_q;
  logic [CW-1:0] comp_q;
  logic [CW:0]   tag_q;

  logic [CW-1:0]    pick_d;
  logic [CW-1:0]    sel_d;
  logic             any_d;
  logic             xfer_d;
  logic             last_row_d;
  logic [N_REQ-1:0] ready_d;
  int unsigned      idx_d;

  // Search begins one past the last completed grant, wrapping modulo N_REQ.
  always_comb begin
    pick_d = '0;
    any_d  = 1'b0;
    idx_d  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx_d = (int'(unsigned'(last_q)) + 1 + i) % N_REQ;
      if (!any_d && bus.req_valid[idx_d]) begin
        any_d  = 1'b1;
        pick_d = CW'(idx_d);
      end
    end
  end

  assign sel_d = (state_q == S_IDLE) ? pick_d : grant_q;

  always_comb begin
    ready_d = '0;
    if (!rst && (state_q == S_BLOCK || any_d)) ready_d[sel_d] = 1'b1;
  end

  assign xfer_d     = |(bus.req_valid & ready_d);
  assign last_row_d = (row_q == RW'(N_ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_q      <= CW'(N_REQ - 1);
      row_q       <= '0;
      dct_valid_q <= 1'b0;
      sob_q       <= 1'b0;
      eob_q       <= 1'b0;
      sof_q       <= 1'b0;
      dct_data_q  <= '0;
      comp_q      <= '0;
    end else begin
      dct_valid_q <= xfer_d;
      sob_q       <= xfer_d && (row_q == '0);
      eob_q       <= xfer_d && last_row_d;
      sof_q       <= xfer_d && (row_q == '0) && bus.req_sof[sel_d];
      if (xfer_d) begin
        dct_data_q <= bus.req_data[sel_d];
        comp_q     <= sel_d;
      end
      case (state_q)
        S_IDLE: begin
          if (xfer_d) begin
            state_q <= S_BLOCK;
            grant_q <= pick_d;
            row_q   <= RW'(1);
          end
        end
        S_BLOCK: begin
          if (xfer_d) begin
            if (last_row_d) begin
              state_q <= S_IDLE;
              last_q  <= grant_q;
              row_q   <= '0;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  dct_tag_pipe #(
    .DEPTH (PIPE),
    .WIDTH (CW + 1)
  ) u_tag_pipe (
    .clk (clk),
    .rst (rst),
    .d_i ({dct_valid_q, comp_q}),
    .q_o (tag_q)
  );

  assign bus.req_ready     = ready_d;
  assign bus.dct_valid     = dct_valid_q;
  assign bus.dct_data      = dct_data_q;
  assign bus.dct_sob       = sob_q;
  assign bus.dct_eob       = eob_q;
  assign bus.dct_sof       = sof_q;
  assign bus.out_tag_valid = tag_q[CW];
  assign bus.out_comp      = tag_q[CW-1:0];
  assign bus.busy          = (state_q == S_BLOCK);

endmodule

// File: tb/tb_dct_sched.sv
// Directed bench for dct_sched: single stream, contention, stall, mid-block reset, sof filtering.
module tb_dct_sched;

  localparam int N_REQ = 3;
  localparam int PIPE  = 8;
  localparam int W_I   = 16;

  typedef logic [7:0][W_I-1:0] row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dct_sched_if #(.N_REQ(N_REQ), .W_I(W_I)) bus ();

  dct_sched #(
    .N_REQ (N_REQ),
    .PIPE  (PIPE),
    .W_I   (W_I)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic row_t row_pat(input int r, input int k);
    row_t v;
    for (int j = 0; j < 8; j++) v[j] = 16'(k * 'h0101) | 16'(j << 12) | 16'(r << 4);
    return v;
  endfunction

  function automatic row_t junk(input int c);
    row_t v;
    for (int j = 0; j < 8; j++) v[j] = 16'hDEAD ^ 16'(c + j);
    return v;
  endfunction

  task automatic check_markers(input string sc, input logic v, input logic sob,
                               input logic eob, input logic sof);
    check_eq({sc, "_valid"}, 128'(bus.dct_valid), 128'(v));
    check_eq({sc, "_sob"},   128'(bus.dct_sob),   128'(sob));
    check_eq({sc, "_eob"},   128'(bus.dct_eob),   128'(eob));
    check_eq({sc, "_sof"},   128'(bus.dct_sof),   128'(sof));
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_sof   = '1;
    bus.req_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 128'(bus.req_ready), 128'(0));
    check_markers("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_busy", 128'(bus.busy), 128'(0));
    check_eq("rst_tagv", 128'(bus.out_tag_valid), 128'(0));
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_sof   = '0;
  endtask

  task automatic scen_single();
    for (int c = 0; c <= 9 + PIPE; c++) begin
      @(posedge clk); #1;
      bus.req_valid   = (c < 8) ? 3'b001 : 3'b000;
      bus.req_data[0] = row_pat(0, c % 8);
      bus.req_sof     = (c == 0) ? 3'b001 : 3'b000;
      @(negedge clk);
      check_eq("s1_ready", 128'(bus.req_ready), 128'((c < 8) ? 1 : 0));
      check_markers("s1", c >= 1 && c <= 8, c == 1, c == 8, c == 1);
      if (c >= 1 && c <= 8) check_eq("s1_data", bus.dct_data, row_pat(0, c - 1));
      check_eq("s1_busy", 128'(bus.busy), 128'(c >= 1 && c <= 7));
      check_eq("s1_tagv", 128'(bus.out_tag_valid), 128'(c >= 1 + PIPE && c <= 8 + PIPE));
      if (c >= 1 + PIPE && c <= 8 + PIPE) check_eq("s1_comp", 128'(bus.out_comp), 128'(0));
    end
  endtask

  task automatic scen_contention();
    logic [2:0] gm;
    int         pc;
    for (int c = 0; c <= 49 + PIPE; c++) begin
      @(posedge clk); #1;
      gm = 3'(1 << ((c / 8) % 3));
      bus.req_valid = (c < 48) ? 3'b111 : 3'b000;
      for (int i = 0; i < N_REQ; i++)
        bus.req_data[i] = gm[i] ? row_pat(i, c % 8) : junk(c);
      bus.req_sof = ~gm | ((c == 0) ? gm : 3'b000);
      @(negedge clk);
      pc = c - 1;
      check_eq("s2_ready", 128'(bus.req_ready), 128'((c < 48) ? gm : 3'b000));
      check_markers("s2", c >= 1 && c <= 48, c >= 1 && c <= 48 && pc % 8 == 0,
                    c >= 1 && c <= 48 && pc % 8 == 7, c == 1);
      if (c >= 1 && c <= 48) check_eq("s2_data", bus.dct_data, row_pat((pc / 8) % 3, pc % 8));
      check_eq("s2_busy", 128'(bus.busy), 128'(c < 48 && c % 8 != 0));
      check_eq("s2_tagv", 128'(bus.out_tag_valid), 128'(c >= 1 + PIPE && c <= 48 + PIPE));
      if (c >= 1 + PIPE && c <= 48 + PIPE)
        check_eq("s2_comp", 128'(bus.out_comp), 128'(((c - 1 - PIPE) / 8) % 3));
    end
  endtask

  task automatic scen_stall();
    logic v1;
    logic xp;
    int   pc;
    row_t ed;
    for (int c = 0; c <= 13; c++) begin
      @(posedge clk); #1;
      v1 = (c <= 4) || (c >= 8 && c <= 10);
      bus.req_valid   = {c <= 12, v1, 1'b0};
      bus.req_data[0] = junk(c);
      bus.req_data[1] = row_pat(1, (c <= 4) ? c : c - 3);
      bus.req_data[2] = row_pat(2, (c >= 11) ? c - 11 : 0);
      bus.req_sof     = '0;
      @(negedge clk);
      pc = c - 1;
      xp = (pc >= 0 && pc <= 4) || (pc >= 8 && pc <= 12);
      check_eq("s3_ready", 128'(bus.req_ready), 128'((c <= 10) ? 3'b010 : 3'b100));
      check_markers("s3", xp, pc == 0 || pc == 11, pc == 10, 1'b0);
      check_eq("s3_busy", 128'(bus.busy), 128'((c >= 1 && c <= 10) || c >= 12));
      if (xp) begin
        ed = (pc <= 4) ? row_pat(1, pc) : (pc <= 10) ? row_pat(1, pc - 3) : row_pat(2, pc - 11);
        check_eq("s3_data", bus.dct_data, ed);
      end
    end
  endtask

  task automatic scen_reset_mid();
    int pc;
    for (int c = 0; c <= 22; c++) begin
      @(posedge clk); #1;
      rst = (c == 4);
      bus.req_valid = (c <= 4) ? 3'b100 : (c == 5) ? 3'b111 : (c <= 12) ? 3'b001 : 3'b000;
      bus.req_data[0] = row_pat(0, (c >= 5 && c <= 12) ? c - 5 : 0);
      bus.req_data[1] = junk(c);
      bus.req_data[2] = row_pat(2, (c <= 4) ? c : 0);
      bus.req_sof     = '0;
      @(negedge clk);
      pc = c - 1;
      check_eq("s4_ready", 128'(bus.req_ready),
               128'((c <= 3) ? 3'b100 : (c >= 5 && c <= 12) ? 3'b001 : 3'b000));
      check_markers("s4", (c >= 1 && c <= 4) || (c >= 6 && c <= 13),
                    c == 1 || c == 6, c == 13, 1'b0);
      check_eq("s4_busy", 128'(bus.busy), 128'((c >= 1 && c <= 4) || (c >= 6 && c <= 12)));
      check_eq("s4_tagv", 128'(bus.out_tag_valid), 128'(c >= 14 && c <= 21));
      if (c >= 14 && c <= 21) check_eq("s4_comp", 128'(bus.out_comp), 128'(0));
      if (c >= 6 && c <= 13) check_eq("s4_data", bus.dct_data, row_pat(0, pc - 5));
    end
  endtask

  task automatic scen_sof_filter();
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1;
      bus.req_valid   = (c < 8) ? 3'b001 : 3'b000;
      bus.req_data[0] = row_pat(0, c % 8);
      bus.req_sof     = (c == 0) ? 3'b000 : 3'b001;
      @(negedge clk);
      check_markers("s5", c >= 1 && c <= 8, c == 1, c == 8, 1'b0);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_sof   = '0;
    do_reset();
    scen_single();
    do_reset();
    scen_contention();
    do_reset();
    scen_stall();
    do_reset();
    scen_reset_mid();
    do_reset();
    scen_sof_filter();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
